levinson_seq: RTL and testbench

- Control FSM that sequences one Levinson-Durbin recursion over a frame's autocorrelation r[0..ORDER].
- Drives the error-update datapath (e_sel/e load), the q multiply-accumulate, an external divider for k, and the coefficient-update write port.
- Sits between the autocorrelation buffer and the LPC coefficient RAM.
- One start pulse yields ORDER reflection coefficients, the updated predictor set, and a done pulse.

---
 rtl/lpc_pkg.sv | 20 ++
 rtl/levinson_idx_cnt.sv | 51 +++++
 rtl/levinson_seq.sv | 256 +++++++++++++++++++++++++
 tb/tb_levinson_seq.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lpc_pkg.sv
// Shared types and default sizing for the LPC analysis blocks.
package lpc_pkg;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        INIT  = 4'd1,
        MAC   = 4'd2,
        DRAIN = 4'd3,
        DIV   = 4'd4,
        UPD   = 4'd5,
        EUPD  = 4'd6,
        FIN   = 4'd7,
        FAIL  = 4'd8
    } state_t;

    localparam int LPC_ORDER   = 10;
    localparam int LPC_ADDR_W  = 4;
    localparam int LPC_MAC_LAT = 2;

endpackage

// File: rtl/levinson_idx_cnt.sv
// Loadable index counter used for both the order index i and the inner index j.
module levinson_idx_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         load_one,
    input  logic         inc,
    input  logic [W-1:0] last_val,
    output logic [W-1:0] cnt,
    output logic [W-1:0] cnt_nxt,
    output logic         is_last
);

    localparam logic [W-1:0] ZERO_C = {W{1'b0}};
    localparam logic [W-1:0] ONE_C  = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] cnt_r;
    logic [W-1:0] cnt_nxt_s;

    // next count: load has priority over increment
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (load) begin
            if (load_one) begin
                cnt_nxt_s = ONE_C;
            end else begin
                cnt_nxt_s = ZERO_C;
            end
        end else if (inc) begin
            cnt_nxt_s = cnt_r + ONE_C;
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // count register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= ZERO_C;
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

    assign cnt     = cnt_r;
    assign cnt_nxt = cnt_nxt_s;
    assign is_last = (cnt_r == last_val);

endmodule

// File: rtl/levinson_seq.sv
// Levinson-Durbin sequencer: walks one recursion over r[0..ORDER], driving the
// error, q-MAC, divider and coefficient-update datapath.
module levinson_seq
    import lpc_pkg::*;
#(
    parameter int ORDER   = LPC_ORDER,
    parameter int ADDR_W  = LPC_ADDR_W,
    parameter int MAC_LAT = LPC_MAC_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic              e_nonpos,
    output logic [ADDR_W-1:0] r_addr,
    output logic [ADDR_W-1:0] a_addr,
    output logic              e_sel,
    output logic              e_en,
    output logic              q_clr,
    output logic              q_en,
    output logic              div_start,
    input  logic              div_done,
    output logic              k_en,
    output logic              a_we,
    output logic [ADDR_W-1:0] a_waddr,
    output logic [ADDR_W-1:0] iter
);

    localparam logic [ADDR_W-1:0] ZERO_A   = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ONE_A    = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ORDER_A  = ADDR_W'(ORDER);
    localparam logic [ADDR_W-1:0] LAT_LAST = ADDR_W'(MAC_LAT) - ONE_A;

    state_t state_r, state_nx_s;

    logic              i_load_s, i_inc_s, i_last_s;
    logic              j_load_s, j_load_one_s, j_inc_s, j_last_s;
    logic [ADDR_W-1:0] i_s, i_nxt_s, j_s, j_nxt_s, j_last_val_s;

    logic              busy_s, done_s, err_s, e_sel_s, e_en_s, q_clr_s, q_en_s;
    logic              div_start_s, a_we_s;
    logic [ADDR_W-1:0] r_addr_s, a_addr_s, a_waddr_s, iter_s;
    logic              busy_r, done_r, err_r, e_sel_r, e_en_r, q_clr_r, q_en_r;
    logic              div_start_r, a_we_r;
    logic [ADDR_W-1:0] r_addr_r, a_addr_r, a_waddr_r, iter_r;

    levinson_idx_cnt #(.W(ADDR_W)) u_i_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (i_load_s),
        .load_one (1'b1),
        .inc      (i_inc_s),
        .last_val (ORDER_A),
        .cnt      (i_s),
        .cnt_nxt  (i_nxt_s),
        .is_last  (i_last_s)
    );

    levinson_idx_cnt #(.W(ADDR_W)) u_j_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (j_load_s),
        .load_one (j_load_one_s),
        .inc      (j_inc_s),
        .last_val (j_last_val_s),
        .cnt      (j_s),
        .cnt_nxt  (j_nxt_s),
        .is_last  (j_last_s)
    );

    // j terminal value depends on which phase is counting
    always_comb begin
        j_last_val_s = ZERO_A;
        case (state_r)
            MAC:     j_last_val_s = i_s - ONE_A;
            DRAIN:   j_last_val_s = LAT_LAST;
            UPD:     j_last_val_s = i_s;
            default: j_last_val_s = ZERO_A;
        endcase
    end

    // next-state and counter control
    always_comb begin
        state_nx_s   = state_r;
        i_load_s     = 1'b0;
        i_inc_s      = 1'b0;
        j_load_s     = 1'b0;
        j_load_one_s = 1'b0;
        j_inc_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nx_s = INIT;
                    i_load_s   = 1'b1;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            INIT: begin
                state_nx_s = MAC;
                j_load_s   = 1'b1;
            end
            MAC: begin
                if ((j_s == ZERO_A) && e_nonpos) begin
                    state_nx_s = FAIL;
                end else if (j_last_s) begin
                    state_nx_s = DRAIN;
                    j_load_s   = 1'b1;
                end else begin
                    j_inc_s = 1'b1;
                end
            end
            DRAIN: begin
                if (j_last_s) begin
                    state_nx_s = DIV;
                    j_load_s   = 1'b1;
                end else begin
                    j_inc_s = 1'b1;
                end
            end
            DIV: begin
                if (div_done) begin
                    state_nx_s   = UPD;
                    j_load_s     = 1'b1;
                    j_load_one_s = 1'b1;
                end else begin
                    j_inc_s = (j_s == ZERO_A);
                end
            end
            UPD: begin
                if (j_last_s) begin
                    state_nx_s = EUPD;
                end else begin
                    j_inc_s = 1'b1;
                end
            end
            EUPD: begin
                if (i_last_s) begin
                    state_nx_s = FIN;
                end else begin
                    state_nx_s = MAC;
                    i_inc_s    = 1'b1;
                    j_load_s   = 1'b1;
                end
            end
            FIN:     state_nx_s = IDLE;
            FAIL:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // output decode from the upcoming state so every strobe leaves a flop
    always_comb begin
        busy_s      = (state_nx_s != IDLE);
        done_s      = 1'b0;
        err_s       = 1'b0;
        e_sel_s     = 1'b0;
        e_en_s      = 1'b0;
        q_clr_s     = 1'b0;
        q_en_s      = 1'b0;
        div_start_s = 1'b0;
        a_we_s      = 1'b0;
        r_addr_s    = ZERO_A;
        a_addr_s    = ZERO_A;
        a_waddr_s   = ZERO_A;
        if (busy_s) begin
            iter_s = i_nxt_s;
        end else begin
            iter_s = ZERO_A;
        end
        case (state_nx_s)
            INIT: begin
                e_en_s  = 1'b1;
                q_clr_s = 1'b1;
            end
            MAC: begin
                q_en_s   = 1'b1;
                a_addr_s = j_nxt_s;
                r_addr_s = i_nxt_s - j_nxt_s;
            end
            DIV:  div_start_s = (state_r == DRAIN);
            UPD: begin
                a_we_s    = 1'b1;
                a_waddr_s = j_nxt_s;
                // final cycle writes k itself, so no partner coefficient is read
                if (j_nxt_s == i_nxt_s) begin
                    a_addr_s = ZERO_A;
                end else begin
                    a_addr_s = i_nxt_s - j_nxt_s;
                end
            end
            EUPD: begin
                e_sel_s = 1'b1;
                e_en_s  = 1'b1;
                q_clr_s = 1'b1;
            end
            FIN:     done_s = 1'b1;
            FAIL:    err_s  = 1'b1;
            default: busy_s = busy_s;
        endcase
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            e_sel_r     <= 1'b0;
            e_en_r      <= 1'b0;
            q_clr_r     <= 1'b0;
            q_en_r      <= 1'b0;
            div_start_r <= 1'b0;
            a_we_r      <= 1'b0;
            r_addr_r    <= ZERO_A;
            a_addr_r    <= ZERO_A;
            a_waddr_r   <= ZERO_A;
            iter_r      <= ZERO_A;
        end else begin
            state_r     <= state_nx_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            err_r       <= err_s;
            e_sel_r     <= e_sel_s;
            e_en_r      <= e_en_s;
            q_clr_r     <= q_clr_s;
            q_en_r      <= q_en_s;
            div_start_r <= div_start_s;
            a_we_r      <= a_we_s;
            r_addr_r    <= r_addr_s;
            a_addr_r    <= a_addr_s;
            a_waddr_r   <= a_waddr_s;
            iter_r      <= iter_s;
        end
    end

    // q_en and k_en react to same-cycle datapath flags, so they are gated here
    assign q_en      = q_en_r & ~(e_nonpos & (j_s == ZERO_A));
    assign k_en      = (state_r == DIV) & div_done;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;
    assign e_sel     = e_sel_r;
    assign e_en      = e_en_r;
    assign q_clr     = q_clr_r;
    assign div_start = div_start_r;
    assign a_we      = a_we_r;
    assign r_addr    = r_addr_r;
    assign a_addr    = a_addr_r;
    assign a_waddr   = a_waddr_r;
    assign iter      = iter_r;

endmodule

// File: tb/tb_levinson_seq.sv
// Bench for levinson_seq: table of runs checked by an event scoreboard, plus reset corner cases.
module tb_levinson_seq;

    localparam int ORDER   = 3;
    localparam int ADDR_W  = 4;
    localparam int MAC_LAT = 2;

    localparam int EV_E = 0;
    localparam int EV_Q = 1;
    localparam int EV_S = 2;
    localparam int EV_K = 3;
    localparam int EV_W = 4;
    localparam int EV_D = 5;
    localparam int EV_X = 6;

    typedef struct {
        int kind;
        int a0;
        int a1;
        bit care_a0;
    } ev_t;

    typedef struct {
        int d;
        int abort_i;
        int inj;
        int exp_cycles;
        int exp_done;
        int exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic e_nonpos;
    logic div_done;
    logic div_done_m = 1'b0;
    logic div_done_man = 1'b0;
    logic div_auto = 1'b1;
    logic busy, done, err, e_sel, e_en, q_clr, q_en, div_start, k_en, a_we;
    logic [ADDR_W-1:0] r_addr, a_addr, a_waddr, iter;

    int abort_i = 0;
    int div_lat = 3;
    int div_cnt = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int n_done = 0;
    int n_err = 0;
    ev_t exp_q[$];
    vec_t vecs[8];

    always #5 clk = ~clk;

    assign e_nonpos = (abort_i != 0) && (int'(iter) == abort_i);
    assign div_done = div_auto ? div_done_m : div_done_man;

    levinson_seq #(.ORDER(ORDER), .ADDR_W(ADDR_W), .MAC_LAT(MAC_LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .e_nonpos  (e_nonpos),
        .r_addr    (r_addr),
        .a_addr    (a_addr),
        .e_sel     (e_sel),
        .e_en      (e_en),
        .q_clr     (q_clr),
        .q_en      (q_en),
        .div_start (div_start),
        .div_done  (div_done),
        .k_en      (k_en),
        .a_we      (a_we),
        .a_waddr   (a_waddr),
        .iter      (iter)
    );

    // divider model: div_done high in the div_lat-th cycle counting the div_start cycle as 1
    always @(posedge clk) begin
        #1;
        if (div_done_m) div_done_m = 1'b0;
        if (!rst_n) begin
            div_cnt = 0;
        end else if (div_start) begin
            div_cnt = 1;
            if (div_lat == 1) begin
                div_done_m = 1'b1;
                div_cnt = 0;
            end
        end else if (div_cnt > 0) begin
            div_cnt++;
            if (div_cnt == div_lat) begin
                div_done_m = 1'b1;
                div_cnt = 0;
            end
        end
    end

    task automatic push_ev(input int k, input int a0, input int a1, input bit c);
        ev_t e;
        e.kind = k; e.a0 = a0; e.a1 = a1; e.care_a0 = c;
        exp_q.push_back(e);
    endtask

    // expected strobe events for one run that aborts at order 'ab' (0 = no abort)
    task automatic push_run(input int ab);
        push_ev(EV_E, 0, 3, 1'b1);
        for (int i = 1; i <= ORDER; i++) begin
            if (i == ab) begin
                push_ev(EV_X, i, 0, 1'b1);
                return;
            end
            for (int j = 0; j < i; j++) push_ev(EV_Q, j, i - j, 1'b1);
            push_ev(EV_S, 0, 0, 1'b1);
            push_ev(EV_K, 0, 0, 1'b1);
            for (int j = 1; j < i; j++) push_ev(EV_W, i - j, j, 1'b1);
            push_ev(EV_W, 0, i, 1'b0);
            push_ev(EV_E, 1, 3, 1'b1);
        end
        push_ev(EV_D, ORDER, 0, 1'b1);
    endtask

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic chk_ev(input int k, input int a0, input int a1);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard: got kind=%0d a0=%0d a1=%0d, expected no event", k, a0, a1);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || (e.care_a0 && e.a0 != a0) || e.a1 != a1) begin
                n_bad++;
                $display("FAIL scoreboard: got kind=%0d a0=%0d a1=%0d, expected kind=%0d a0=%0d a1=%0d",
                         k, a0, a1, e.kind, e.a0, e.a1);
            end
        end
    endtask

    task automatic mon();
        if (e_en || q_clr) chk_ev(EV_E, int'(e_sel), int'({e_en, q_clr}));
        if (q_en)      chk_ev(EV_Q, int'(a_addr), int'(r_addr));
        if (div_start) chk_ev(EV_S, 0, 0);
        if (k_en)      chk_ev(EV_K, 0, 0);
        if (a_we)      chk_ev(EV_W, int'(a_addr), int'(a_waddr));
        if (done) begin n_done++; chk_ev(EV_D, int'(iter), 0); end
        if (err)  begin n_err++;  chk_ev(EV_X, int'(iter), 0); end
    endtask

    task automatic tick();
        @(negedge clk);
        mon();
    endtask

    task automatic run_one(input vec_t v);
        int cycles;
        bit injected;
        div_lat = v.d;
        abort_i = v.abort_i;
        n_done = 0;
        n_err = 0;
        exp_q.delete();
        push_run(v.abort_i);
        start = 1'b1;
        tick();
        start = 1'b0;
        cycles = 0;
        injected = 1'b0;
        while (busy && cycles < 1000) begin
            cycles++;
            if (v.inj == 1 && a_we && !injected) begin
                start = 1'b1;
                injected = 1'b1;
            end else if (v.inj == 2 && done) begin
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        repeat (3) tick();
        check("run_cycles", cycles, v.exp_cycles);
        check("done_pulses", n_done, v.exp_done);
        check("err_pulses", n_err, v.exp_err);
        check("sb_leftover", exp_q.size(), 0);
        check("idle_after_run", int'(busy), 0);
        abort_i = 0;
    endtask

    initial begin
        int cyc;
        vecs[0] = '{3, 0, 0, 32, 1, 0};
        vecs[1] = '{1, 0, 0, 26, 1, 0};
        vecs[2] = '{5, 0, 0, 38, 1, 0};
        vecs[3] = '{3, 2, 0, 11, 0, 1};
        vecs[4] = '{2, 1, 0,  3, 0, 1};
        vecs[5] = '{1, 3, 0, 17, 0, 1};
        vecs[6] = '{2, 0, 1, 29, 1, 0};
        vecs[7] = '{2, 0, 2, 29, 1, 0};

        // reset then idle
        rst_n = 1'b0;
        tick();
        tick();
        check("reset_outputs", int'({busy, done, err, e_sel, e_en, q_clr, q_en, div_start, k_en, a_we,
                                    r_addr, a_addr, a_waddr, iter}), 0);
        rst_n = 1'b1;
        tick();
        tick();
        check("idle_outputs", int'({busy, done, err, e_sel, e_en, q_clr, q_en, div_start, k_en, a_we,
                                   r_addr, a_addr, a_waddr}), 0);
        check("idle_iter", int'(iter), 0);

        for (int n = 0; n < 8; n++) run_one(vecs[n]);

        // reset while the divider is outstanding
        div_auto = 1'b0;
        div_done_man = 1'b0;
        exp_q.delete();
        push_ev(EV_E, 0, 3, 1'b1);
        push_ev(EV_Q, 0, 1, 1'b1);
        push_ev(EV_S, 0, 0, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (!div_start && cyc < 100) begin
            cyc++;
            tick();
        end
        check("div_start_seen", int'(div_start), 1);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_div_reset_busy", int'(busy), 0);
        check("mid_div_reset_iter", int'(iter), 0);
        div_done_man = 1'b1;
        tick();
        check("late_div_done_k_en", int'(k_en), 0);
        check("late_div_done_a_we", int'(a_we), 0);
        div_done_man = 1'b0;
        tick();
        tick();
        check("mid_div_idle", int'(busy), 0);
        check("mid_div_sb_leftover", exp_q.size(), 0);
        div_auto = 1'b1;
        run_one(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
